uart1_rx: RTL and testbench

//  Serial receiver for the UART1 link. Deserialises frames produced by the UART1 transmitter.

---
 rtl/uart1_pkg.sv | 20 ++
 rtl/uart1_rx_if.sv | 33 +++
 rtl/uart1_sync.sv | 25 ++
 rtl/uart1_rx.sv | 179 +++++++++++++++++
 tb/tb_uart1_rx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart1_pkg.sv
// Shared UART1 definitions: FSM state encoding, frame width and parity helper.
package uart1_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_t;

    // Parity bit a transmitter puts on the line for this data word.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart1_rx_if.sv
// Receive-side byte stream: valid/ready handshake plus frame qualifiers.
interface uart1_rx_if;
    import uart1_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output parity_err,
        output frame_err,
        output overrun_err,
        output busy
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        input  busy
    );

endinterface

// File: rtl/uart1_sync.sv
// Multi-flop synchroniser for an asynchronous line; resets to 1 so an idle line
// never looks like a start bit coming out of reset.
module uart1_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/uart1_rx.sv
// UART1 receiver: start/8 data/parity/stop frame deserialiser with a one-entry
// valid/ready output register and parity, framing and overrun reporting.
module uart1_rx
    import uart1_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      serial_in,
    uart1_rx_if.master rx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    logic s_in;

    state_t               state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 complete;
    logic                 stop_bad;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;

    uart1_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (serial_in),
        .q     (s_in)
    );

    // Frame FSM, bit timing and shift register next-state.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        complete  = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!s_in) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    // One clock per bit: this cycle already is the start-bit sample.
                    state_d   = (CLKS_PER_BIT == 1) ? StData : StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = s_in ? StIdle : StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            StData: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    shreg_d   = {s_in, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            StParity: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    perr_d    = s_in ^ parity_bit(shreg_q, ODD);
                    state_d   = StStop;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    complete  = 1'b1;
                    stop_bad  = !s_in;
                    state_d   = s_in ? StIdle : StBreak;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            StBreak: begin
                // Line must return high before another start can be recognised.
                if (s_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
        end
    end

    // Output holding register: load on completion, clear on transfer, flag overrun.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;
        if (complete) begin
            // A coincident transfer frees the slot, so the new byte wins.
            if (!valid_q || rx.rx_ready) begin
                data_d     = shreg_q;
                valid_d    = 1'b1;
                perr_out_d = perr_q;
                ferr_out_d = stop_bad;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx.rx_ready) begin
            valid_d    = 1'b0;
            perr_out_d = 1'b0;
            ferr_out_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx.rx_data     = data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.parity_err  = perr_out_q;
    assign rx.frame_err   = ferr_out_q;
    assign rx.overrun_err = ovr_q;
    assign rx.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart1_rx.sv
// Bench for uart1_rx: one instance at 1 clock/bit and one at 16 clocks/bit, driven
// by a frame-level transmitter model and checked against expected byte records.
module tb_uart1_rx;

    typedef struct {
        int         d;
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ser;
    logic       rdy [2];
    logic [7:0] dat [2];
    logic       val [2];
    logic       pe  [2];
    logic       fe  [2];
    logic       ov  [2];
    logic       bsy [2];

    int   total = 0;
    int   bad   = 0;
    int   ovr [2] = '{0, 0};
    rec_t obs [$];
    vec_t vecs [5];

    always #5 clk = ~clk;

    uart1_rx_if if0 ();
    uart1_rx_if if1 ();

    uart1_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .serial_in(ser[0]), .rx(if0)
    );
    uart1_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .serial_in(ser[1]), .rx(if1)
    );

    assign if0.rx_ready = rdy[0];
    assign if1.rx_ready = rdy[1];
    assign dat[0] = if0.rx_data;     assign dat[1] = if1.rx_data;
    assign val[0] = if0.rx_valid;    assign val[1] = if1.rx_valid;
    assign pe[0]  = if0.parity_err;  assign pe[1]  = if1.parity_err;
    assign fe[0]  = if0.frame_err;   assign fe[1]  = if1.frame_err;
    assign ov[0]  = if0.overrun_err; assign ov[1]  = if1.overrun_err;
    assign bsy[0] = if0.busy;        assign bsy[1] = if1.busy;

    // Record every accepted byte and count overrun pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (val[d] && rdy[d]) obs.push_back('{d: d, data: dat[d], pe: pe[d], fe: fe[d]});
                if (ov[d]) ovr[d] = ovr[d] + 1;
            end
        end
    end

    function automatic int cpb_of(input int d);
        return (d == 0) ? 1 : 16;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cpb=%0d): got 0x%0h expected 0x%0h", name, cpb_of(d), act, exp);
        end
    endtask

    task automatic send_bit(input int d, input logic b);
        ser[d] = b;
        tick(cpb_of(d));
    endtask

    // Even-parity transmitter; flip corrupts the parity bit.
    task automatic send_frame(input int d, input logic [7:0] data, input logic flip,
                              input logic stop);
        send_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d, data[i]);
        send_bit(d, (^data) ^ flip);
        send_bit(d, stop);
    endtask

    task automatic idle(input int d, input int nbits);
        ser[d] = 1'b1;
        tick(nbits * cpb_of(d));
    endtask

    task automatic expect_rec(input int d, input logic [7:0] data, input logic perr,
                              input logic ferr);
        rec_t r;
        int   waited = 0;
        while (obs.size() == 0 && waited < 64 * cpb_of(d)) begin
            tick(1);
            waited++;
        end
        if (obs.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_timeout (cpb=%0d): no byte, expected 0x%0h", cpb_of(d), data);
        end else begin
            r = obs.pop_front();
            check("rx_dut", d, r.d, d);
            check("rx_data", d, r.data, data);
            check("rx_perr", d, r.pe, perr);
            check("rx_ferr", d, r.fe, ferr);
        end
    endtask

    task automatic check_reset_outputs(input int d, input string name);
        check({name, "_data"}, d, dat[d], 8'h00);
        check({name, "_flags"}, d, {val[d], pe[d], fe[d], ov[d], bsy[d]}, 5'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int ob;
        logic saw;
        logic [7:0] rd;
        logic rf;
        logic rs;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

        ser    = 2'b11;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        rst_n  = 1'b0;
        tick(3);
        check_reset_outputs(0, "reset");
        check_reset_outputs(1, "reset");
        rst_n = 1'b1;
        tick(4);

        // Exact latency at one clock per bit: valid three cycles after the stop bit.
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        ser[0] = 1'b1;
        check("lat_valid_k1", 0, val[0], 1'b0);
        tick(1);
        check("lat_valid_k2", 0, val[0], 1'b0);
        tick(1);
        check("lat_valid_k3", 0, {val[0], dat[0], pe[0], fe[0]}, {1'b1, 8'hA5, 2'b00});
        tick(1);
        check("lat_valid_k4", 0, val[0], 1'b0);
        expect_rec(0, 8'hA5, 1'b0, 1'b0);
        idle(0, 2);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 5; i++) begin
                send_frame(d, vecs[i].data, vecs[i].flip, vecs[i].stop);
                idle(d, 4);
                expect_rec(d, vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
            end

            // Stop bit low, line held low: break, then a clean frame.
            send_frame(d, 8'h3C, 1'b0, 1'b0);
            ser[d] = 1'b0;
            nb = 0;
            for (int i = 0; i < 20 * cpb_of(d); i++) begin
                tick(1);
                if (!bsy[d]) nb++;
            end
            check("break_busy_low", d, nb, 0);
            idle(d, 4);
            check("break_busy_idle", d, bsy[d], 1'b0);
            send_frame(d, 8'h55, 1'b0, 1'b1);
            idle(d, 2);
            expect_rec(d, 8'h3C, 1'b0, 1'b1);
            expect_rec(d, 8'h55, 1'b0, 1'b0);

            // Consumer stalled: second frame is dropped with one overrun pulse.
            rdy[d] = 1'b0;
            ob = ovr[d];
            send_frame(d, 8'h11, 1'b0, 1'b1);
            send_frame(d, 8'h22, 1'b0, 1'b1);
            idle(d, 3);
            check("ovr_hold", d, {val[d], dat[d]}, {1'b1, 8'h11});
            check("ovr_pulses", d, ovr[d] - ob, 1);
            check("ovr_no_xfer", d, obs.size(), 0);
            rdy[d] = 1'b1;
            expect_rec(d, 8'h11, 1'b0, 1'b0);
            tick(2);
            check("ovr_drained", d, {val[d], 31'(obs.size())}, 32'd0);

            // Random frames against the frame-level model.
            for (int n = 0; n < 6; n++) begin
                rd = 8'($urandom);
                rf = ($urandom_range(0, 3) == 0);
                rs = ($urandom_range(0, 3) != 0);
                send_frame(d, rd, rf, rs);
                idle(d, rs ? int'($urandom_range(1, 3)) : 4);
                expect_rec(d, rd, rf, !rs);
            end
            idle(d, 2);

            // Reset in the middle of data bit 4 of 0x7E discards the frame.
            send_bit(d, 1'b0);
            for (int i = 0; i < 4; i++) send_bit(d, (8'h7E >> i) & 8'h01);
            ser[d] = 1'b1;
            tick(cpb_of(d) / 2);
            rst_n = 1'b0;
            tick(2);
            check_reset_outputs(d, "midrst");
            ser[d] = 1'b1;
            tick(1);
            rst_n = 1'b1;
            idle(d, 2);
            send_frame(d, 8'h81, 1'b0, 1'b1);
            idle(d, 2);
            expect_rec(d, 8'h81, 1'b0, 1'b0);
            check("midrst_no_extra", d, obs.size(), 0);
        end

        // Short low glitch at 16 clocks per bit is rejected as a false start.
        idle(1, 2);
        ser[1] = 1'b0;
        tick(3);
        ser[1] = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (bsy[1]) saw = 1'b1;
        end
        check("glitch_busy_seen", 1, saw, 1'b1);
        check("glitch_busy_clear", 1, bsy[1], 1'b0);
        tick(32);
        check("glitch_no_byte", 1, {val[1], 31'(obs.size())}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
